// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared widths, state encodings and target arithmetic for the next-PC sequencer
package pc_sequencer_pkg;

  localparam int PC_W = 16;
  localparam logic [PC_W-1:0] RESET_VECTOR_DEF = 16'h0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_t;

  // Branch offsets are relative to the instruction after the branch; wraps mod 2^16.
  function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] br_pc,
                                                   input logic [PC_W-1:0] inc,
                                                   input logic [PC_W-1:0] offset);
    return br_pc + inc + offset;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - redirect sources in, fetch PC and pipeline control out
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;

  logic            stall;
  logic            jump_req;
  logic [PC_W-1:0] jump_target;
  logic            br_req;
  logic            br_taken;
  logic [PC_W-1:0] br_pc;
  logic [PC_W-1:0] br_offset;
  logic            halt_req;
  logic            resume;

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus;
  logic [PC_W-1:0] pc_target;
  logic            choice;
  logic            fetch_valid;
  logic            flush;
  logic            halted;

  modport master (
    output stall, jump_req, jump_target, br_req, br_taken, br_pc, br_offset, halt_req, resume,
    input  pc, pc_plus, pc_target, choice, fetch_valid, flush, halted
  );

  modport slave (
    input  stall, jump_req, jump_target, br_req, br_taken, br_pc, br_offset, halt_req, resume,
    output pc, pc_plus, pc_target, choice, fetch_valid, flush, halted
  );

endinterface

// File: rtl/pc_sequencer_mpc.sv
// rtl/pc_sequencer_mpc.sv - two-way PC mux: sequential (pcp) or redirect (pcj)
module pc_sequencer_mpc #(
  parameter int W = 16
) (
  input  logic [W-1:0] pcp,
  input  logic [W-1:0] pcj,
  input  logic         choice,
  output logic [W-1:0] out
);

  assign out = choice ? pcj : pcp;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register, redirect arbitration, stall/pending, flush and halt control
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [PC_W-1:0] PC_INC       = 16'd1,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.slave  bus
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);
  localparam seq_state_t AFTER_REDIR = (FLUSH_CYCLES != 0) ? ST_FLUSH : ST_RUN;

  seq_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pend_q, pend_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            pc_load;

  logic            br_win;
  logic            redir;
  logic [PC_W-1:0] redir_tgt;
  logic [PC_W-1:0] pc_plus;
  logic [PC_W-1:0] pc_target;
  logic [PC_W-1:0] pc_next;
  logic            choice;
  logic            flush;
  logic            halted;
  logic            fetch_valid;

  // The branch is older than the jump in decode, so it wins a same-cycle conflict.
  assign br_win    = bus.br_req && bus.br_taken;
  assign redir     = br_win || bus.jump_req;
  assign redir_tgt = br_win ? branch_target(bus.br_pc, PC_INC, bus.br_offset) : bus.jump_target;
  assign pc_plus   = pc_q + PC_INC;

  pc_sequencer_mpc #(.W(PC_W)) u_mpc (
    .pcp    (pc_plus),
    .pcj    (pc_target),
    .choice (choice),
    .out    (pc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VECTOR;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      if (pc_load) begin
        pc_q <= pc_next;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    pc_load = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (redir) begin
          if (bus.stall) begin
            pend_d  = redir_tgt;
            state_d = ST_PEND;
          end else begin
            pc_load = 1'b1;
            cnt_d   = FLUSH_LOAD;
            state_d = AFTER_REDIR;
          end
        end else if (bus.halt_req && !bus.stall) begin
          state_d = ST_HALT;
        end else begin
          pc_load = !bus.stall;
        end
      end
      ST_PEND: begin
        if (redir) begin
          pend_d = redir_tgt;
        end
        if (!bus.stall) begin
          pc_load = 1'b1;
          pend_d  = '0;
          cnt_d   = FLUSH_LOAD;
          state_d = AFTER_REDIR;
        end
      end
      ST_FLUSH: begin
        // Requests here come from squashed instructions and are dropped.
        pc_load = !bus.stall;
        cnt_d   = (cnt_q != 2'd0) ? cnt_q - 2'd1 : 2'd0;
        if (cnt_q <= 2'd1) begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        if (bus.resume) begin
          pc_load = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    choice    = 1'b0;
    pc_target = '0;
    flush     = 1'b0;
    halted    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (redir) begin
          pc_target = redir_tgt;
        end
        choice = redir && !bus.stall;
      end
      ST_PEND: begin
        pc_target = redir ? redir_tgt : pend_q;
        choice    = !bus.stall;
      end
      ST_FLUSH: flush  = 1'b1;
      ST_HALT:  halted = 1'b1;
      default: ;
    endcase
    fetch_valid = !bus.stall && (state_q != ST_HALT) && (state_q != ST_PEND);
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus     = pc_plus;
  assign bus.pc_target   = pc_target;
  assign bus.choice      = choice;
  assign bus.fetch_valid = fetch_valid;
  assign bus.flush       = flush;
  assign bus.halted      = halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_VECTOR (16'h0000),
    .PC_INC       (16'd1),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall       = 1'b0;
    bus.jump_req    = 1'b0;
    bus.jump_target = 16'h0000;
    bus.br_req      = 1'b0;
    bus.br_taken    = 1'b0;
    bus.br_pc       = 16'h0000;
    bus.br_offset   = 16'h0000;
    bus.halt_req    = 1'b0;
    bus.resume      = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    idle_inputs();

    // reset state
    #12;
    chk("rst_pc", bus.pc, 16'h0000);
    chk("rst_choice", 16'(bus.choice), 16'h0);
    chk("rst_flush", 16'(bus.flush), 16'h0);
    chk("rst_halted", 16'(bus.halted), 16'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_fetch_valid", 16'(bus.fetch_valid), 16'h1);
    chk("rst_pc_plus", bus.pc_plus, 16'h0001);

    // free run
    step();
    chk("run_pc1", bus.pc, 16'h0001);
    step();
    chk("run_pc2", bus.pc, 16'h0002);
    chk("run_choice", 16'(bus.choice), 16'h0);

    // jump at pc=2
    bus.jump_req    = 1'b1;
    bus.jump_target = 16'h007C;
    #1;
    chk("jmp_choice", 16'(bus.choice), 16'h1);
    chk("jmp_target", bus.pc_target, 16'h007C);
    step();
    chk("jmp_pc", bus.pc, 16'h007C);
    chk("jmp_flush1", 16'(bus.flush), 16'h1);
    bus.jump_target = 16'h0200;
    #1;
    chk("flush_ignore_choice", 16'(bus.choice), 16'h0);
    step();
    chk("flush_pc2", bus.pc, 16'h007D);
    chk("jmp_flush2", 16'(bus.flush), 16'h1);
    bus.jump_req = 1'b0;
    step();
    chk("flush_end_pc", bus.pc, 16'h007E);
    chk("flush_end", 16'(bus.flush), 16'h0);

    // branch beats jump in same cycle: 0x10 + 1 - 4 = 0x0D
    bus.jump_req    = 1'b1;
    bus.jump_target = 16'h0100;
    bus.br_req      = 1'b1;
    bus.br_taken    = 1'b1;
    bus.br_pc       = 16'h0010;
    bus.br_offset   = 16'hFFFC;
    #1;
    chk("brj_target", bus.pc_target, 16'h000D);
    chk("brj_choice", 16'(bus.choice), 16'h1);
    step();
    idle_inputs();
    chk("brj_pc", bus.pc, 16'h000D);
    step();
    step();
    chk("brj_after_flush_pc", bus.pc, 16'h000F);
    chk("brj_after_flush", 16'(bus.flush), 16'h0);

    // redirect under stall goes pending
    bus.stall       = 1'b1;
    bus.jump_req    = 1'b1;
    bus.jump_target = 16'h0040;
    #1;
    chk("stall_fetch_valid", 16'(bus.fetch_valid), 16'h0);
    chk("stall_choice", 16'(bus.choice), 16'h0);
    step();
    chk("pend_pc1", bus.pc, 16'h000F);
    step();
    chk("pend_pc2", bus.pc, 16'h000F);
    chk("pend_choice", 16'(bus.choice), 16'h0);
    bus.stall    = 1'b0;
    bus.jump_req = 1'b0;
    #1;
    chk("pend_release_choice", 16'(bus.choice), 16'h1);
    chk("pend_release_target", bus.pc_target, 16'h0040);
    chk("pend_fetch_valid", 16'(bus.fetch_valid), 16'h0);
    step();
    chk("pend_pc_target", bus.pc, 16'h0040);
    chk("pend_flush", 16'(bus.flush), 16'h1);
    step();
    step();
    chk("pend_done_pc", bus.pc, 16'h0042);
    chk("pend_done_flush", 16'(bus.flush), 16'h0);

    // wrap: jump near top of memory
    bus.jump_req    = 1'b1;
    bus.jump_target = 16'hFFFD;
    step();
    bus.jump_req = 1'b0;
    step();
    step();
    chk("wrap_pc_ffff", bus.pc, 16'hFFFF);
    chk("wrap_pc_plus", bus.pc_plus, 16'h0000);
    step();
    chk("wrap_pc_0", bus.pc, 16'h0000);

    // branch target wraps: 0xFFFE + 1 + 3 = 0x0002
    bus.br_req    = 1'b1;
    bus.br_taken  = 1'b1;
    bus.br_pc     = 16'hFFFE;
    bus.br_offset = 16'h0003;
    #1;
    chk("brwrap_target", bus.pc_target, 16'h0002);
    step();
    idle_inputs();
    chk("brwrap_pc", bus.pc, 16'h0002);

    // not-taken branch is not a redirect
    step();
    step();
    bus.br_req   = 1'b1;
    bus.br_taken = 1'b0;
    bus.br_pc    = 16'h0100;
    #1;
    chk("ntaken_choice", 16'(bus.choice), 16'h0);
    step();
    idle_inputs();
    chk("ntaken_pc", bus.pc, 16'h0005);

    // halt at pc=5
    bus.halt_req = 1'b1;
    step();
    bus.halt_req = 1'b0;
    chk("halt_halted", 16'(bus.halted), 16'h1);
    chk("halt_fetch_valid", 16'(bus.fetch_valid), 16'h0);
    chk("halt_pc0", bus.pc, 16'h0005);
    bus.jump_req    = 1'b1;
    bus.jump_target = 16'h0300;
    step();
    chk("halt_pc1", bus.pc, 16'h0005);
    bus.jump_req = 1'b0;
    step();
    step();
    chk("halt_pc3", bus.pc, 16'h0005);
    bus.resume = 1'b1;
    step();
    bus.resume = 1'b0;
    chk("resume_pc", bus.pc, 16'h0006);
    chk("resume_halted", 16'(bus.halted), 16'h0);

    // halt again, then async reset inside HALT
    bus.halt_req = 1'b1;
    step();
    bus.halt_req = 1'b0;
    chk("halt2_halted", 16'(bus.halted), 16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_halt_pc", bus.pc, 16'h0000);
    chk("rst_halt_halted", 16'(bus.halted), 16'h0);
    rst_n = 1'b1;
    step();
    chk("post_rst_pc", bus.pc, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
